bcd_counter: RTL and testbench
==============================

# bcd_counter

Four-digit synchronous BCD up/down counter with a programmable tick prescaler, parallel load and leading-zero blanking. It sits directly upstream of the per-digit BCD-to-seven-segment decoders: each 4-bit nibble of `disp` drives one decoder input. The decoders render any code above 9 as an all-off digit, so `disp` uses 4'hF to blank a digit.

## Interface
Parameters:
- `TICK_DIV`, default 1_000_000: clock cycles per count step while enabled; legal range 1 to 2^24-1.
- `LZB`, default 1: 1 enables leading-zero blanking on `disp`; 0 makes `disp` equal `bcd`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; when 0, the prescaler and count hold.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `clr`  in  1  synchronous clear.
- `ld`  in  1  synchronous parallel load strobe.
- `ld_val`  in  16  BCD load value, 4 nibbles, digit 3 in [15:12].
- `bcd`  out  16  current count, 4 BCD digits, digit 0 in [3:0].
- `disp`  out  16  display value; blanked digits read 4'hF.
- `tick`  out  1  one-cycle pulse on every count step.
- `wrap`  out  1  one-cycle pulse when the count wraps.
- `ld_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset (`rst_n`=0, asynchronous) sets: `bcd`=16'h0000; prescaler=0; `tick`=0, `wrap`=0, `ld_err`=0. `disp`=16'hFFF0 when LZB=1, 16'h0000 when LZB=0.
- Per-cycle priority is `clr`, then `ld`, then step, then hold.
- `clr`=1: `bcd`←0 and prescaler←0, regardless of `en`. `tick`/`wrap` are not asserted.
- `ld`=1, all `ld_val` nibbles ≤9: `bcd`←`ld_val` and prescaler←0.
- `ld`=1, any nibble >9: `bcd` and prescaler unchanged; `ld_err` pulses for 1 cycle.
- Prescaler, when `en`=1 and there is no clr/ld: counts 0..TICK_DIV-1 and wraps to 0. The cycle where prescaler==TICK_DIV-1 is a step cycle.
- With TICK_DIV=1, every enabled cycle is a step cycle.
- `en`=0: the prescaler holds its value and does not reset; counting resumes from that value.
- Up step:
  - Digit 0 increments; a digit at 9 becomes 0 and carries to the next digit.
  - 9999→0000 asserts `wrap`.
- Down step:
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - 0000→9999 asserts `wrap`.
- `up` is sampled only on step cycles. A direction change takes effect on the next step with no extra delay.
- `bcd` never holds a nibble >9 in any reachable state.
- Leading-zero blanking (`disp`, combinational from `bcd`, LZB=1):
  - Digit k (k=3..1) is blanked (4'hF) iff digit k and every higher digit are 0.
  - Digit 0 is never blanked.
  - Example: 0040 → disp FF40; 0000 → FFF0.

## Timing
- `bcd` is registered. It updates on the rising edge that ends a step, clr or ld cycle: 1-cycle latency from the input to `bcd`.
- `tick` and `wrap` are registered. They are high in the cycle immediately after the step cycle, aligned with the new `bcd` value.
- `ld_err` is registered and high in the cycle after the rejected `ld`.
- `disp` is combinational from `bcd` and adds no latency.
- From clr or a valid ld with `en` held at 1, the first step occurs TICK_DIV cycles later.
- `clr` or `ld` coinciding with a step cycle suppresses that step: no `tick`, no `wrap`.
- `rst_n` asserted mid-count forces the reset values immediately, without waiting for a clock edge. The first step after deassertion needs the full TICK_DIV enabled cycles.
- No combinational path exists from any input to `bcd`, `tick`, `wrap` or `ld_err`.

## Test plan
Unless noted, TICK_DIV=4 and LZB=1.
- Reset release with `en`=1, `up`=1: after 4 cycles `bcd`=0001 and `tick` pulses; after 40 cycles `bcd`=0010 and `disp`=FF10.
- Load 0999 then count up: next step gives 1000; load 9999, one step gives 0000 with `wrap`=1 for exactly 1 cycle.
- Down count from a load of 0000: first step gives 9999 with `wrap`; load 1000, one down step gives 0999 and `disp`=F999.
- `ld_val`=16'h12A4: `bcd` unchanged, `ld_err`=1 for 1 cycle. Then `ld`+`clr` in the same cycle: `bcd`=0000 (clr wins), no `ld_err`.
- `en` dropped when prescaler=2, held low 10 cycles, then raised: next step arrives after 2 more enabled cycles. `clr` asserted on a step cycle: no `tick`, `bcd`=0000.
- TICK_DIV=1 with `up` toggled every cycle from 0005: `bcd` goes 0006, 0005, 0006… Async `rst_n` pulse mid-cycle: `bcd`=0000 before the next clock edge.

Source files
------------

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter
//  Purpose  : Four-digit BCD up/down counter with tick prescaler, parallel
//             load with validity check, and leading-zero blanking for the
//             downstream seven-segment decoders (4'hF renders as blank).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_counter #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter bit          LZB      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        ld,
  input  logic [15:0] ld_val,
  output logic [15:0] bcd,
  output logic [15:0] disp,
  output logic        tick,
  output logic        wrap,
  output logic        ld_err
);

  localparam int unsigned     PS_W    = 24;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [15:0]     bcd_q, bcd_d;
  logic [PS_W-1:0] psc_q, psc_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            ld_err_q, ld_err_d;

  logic [15:0]     step_val;
  logic            step_wrap;
  logic            ripple;
  logic            ld_ok;

  // A load is accepted only if every nibble is a legal BCD digit.
  always_comb begin
    ld_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (ld_val[4*k +: 4] > 4'd9) ld_ok = 1'b0;
    end
  end

  // Value after one step: ripple carry (up) or borrow (down) from digit 0.
  always_comb begin
    step_val = bcd_q;
    ripple   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (ripple) begin
        if (up) begin
          if (bcd_q[4*k +: 4] == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (bcd_q[4*k +: 4] == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
    // A carry/borrow out of digit 3 means 9999->0000 or 0000->9999.
    step_wrap = ripple;
  end

  // Next-state selection: clr beats ld beats step beats hold.
  always_comb begin
    bcd_d    = bcd_q;
    psc_d    = psc_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (clr) begin
      bcd_d = 16'h0000;
      psc_d = '0;
    end else if (ld) begin
      if (ld_ok) begin
        bcd_d = ld_val;
        psc_d = '0;
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (en) begin
      if (psc_q == PS_LAST) begin
        psc_d  = '0;
        bcd_d  = step_val;
        tick_d = 1'b1;
        wrap_d = step_wrap;
      end else begin
        psc_d = psc_q + {{(PS_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // State and pulse registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q    <= 16'h0000;
      psc_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      psc_q    <= psc_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bcd    = bcd_q;
  assign tick   = tick_q;
  assign wrap   = wrap_q;
  assign ld_err = ld_err_q;

  generate
    if (LZB) begin : g_lzb
      logic zero_run;
      // Blank digits 3..1 while they and all higher digits are zero.
      always_comb begin
        disp     = bcd_q;
        zero_run = 1'b1;
        for (int k = 3; k >= 1; k--) begin
          zero_run = zero_run & (bcd_q[4*k +: 4] == 4'd0);
          if (zero_run) disp[4*k +: 4] = 4'hF;
        end
      end
    end else begin : g_no_lzb
      assign disp = bcd_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_counter
//  Purpose  : Self-checking bench for bcd_counter (TICK_DIV 4 and 1, LZB 1
//             and 0) against an integer-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter;

  logic        clk;
  logic        rst_n;
  logic        en, up, clr, ld;
  logic [15:0] ld_val;

  logic [15:0] bcd4, disp4, bcd1, disp1, bcdn, dispn;
  logic        tick4, wrap4, err4, tick1, wrap1, err1, tickn, wrapn, errn;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: index 0 -> TICK_DIV 4, index 1 -> TICK_DIV 1.
  int m_cnt  [2];
  int m_psc  [2];
  int m_tick [2];
  int m_wrap [2];
  int m_err  [2];
  int m_div  [2] = '{4, 1};

  bcd_counter #(.TICK_DIV(4), .LZB(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .bcd(bcd4), .disp(disp4), .tick(tick4), .wrap(wrap4),
    .ld_err(err4));

  bcd_counter #(.TICK_DIV(1), .LZB(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .bcd(bcd1), .disp(disp1), .tick(tick1), .wrap(wrap1),
    .ld_err(err1));

  bcd_counter #(.TICK_DIV(4), .LZB(1'b0)) dutn (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .bcd(bcdn), .disp(dispn), .tick(tickn), .wrap(wrapn),
    .ld_err(errn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_legal(input logic [15:0] b);
    return (b[15:12] <= 9) && (b[11:8] <= 9) && (b[7:4] <= 9) && (b[3:0] <= 9);
  endfunction

  function automatic logic [15:0] blank_disp(input int v);
    logic [15:0] d;
    d = to_bcd(v);
    if (v < 1000) d[15:12] = 4'hF;
    if (v < 100)  d[11:8]  = 4'hF;
    if (v < 10)   d[7:4]   = 4'hF;
    return d;
  endfunction

  // Reference model: decimal count advanced with modular arithmetic.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_psc[i] = 0; m_tick[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      end else begin
        m_tick[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
        if (clr) begin
          m_cnt[i] = 0; m_psc[i] = 0;
        end else if (ld) begin
          if (bcd_legal(ld_val)) begin
            m_cnt[i] = from_bcd(ld_val); m_psc[i] = 0;
          end else begin
            m_err[i] = 1;
          end
        end else if (en) begin
          if (m_psc[i] == m_div[i] - 1) begin
            m_psc[i]  = 0;
            m_tick[i] = 1;
            if (up) begin
              m_wrap[i] = (m_cnt[i] == 9999) ? 1 : 0;
              m_cnt[i]  = (m_cnt[i] + 1) % 10000;
            end else begin
              m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
              m_cnt[i]  = (m_cnt[i] + 9999) % 10000;
            end
          end else begin
            m_psc[i] = m_psc[i] + 1;
          end
        end
      end
    end
  end

  // Scoreboard: every output of every instance against the model each cycle.
  always @(negedge clk) begin
    chk("bcd4",  bcd4,  to_bcd(m_cnt[0]));
    chk("disp4", disp4, blank_disp(m_cnt[0]));
    chk("tick4", tick4, m_tick[0]);
    chk("wrap4", wrap4, m_wrap[0]);
    chk("err4",  err4,  m_err[0]);
    chk("bcd1",  bcd1,  to_bcd(m_cnt[1]));
    chk("disp1", disp1, blank_disp(m_cnt[1]));
    chk("tick1", tick1, m_tick[1]);
    chk("wrap1", wrap1, m_wrap[1]);
    chk("err1",  err1,  m_err[1]);
    chk("bcdn",  bcdn,  to_bcd(m_cnt[0]));
    chk("dispn", dispn, to_bcd(m_cnt[0]));
    chk("tickn", tickn, m_tick[0]);
    chk("wrapn", wrapn, m_wrap[0]);
    chk("errn",  errn,  m_err[0]);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ld(input logic [15:0] v);
    ld = 1'b1; ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = 16'h0000;
    #1 rst_n = 1'b0;
    cyc(2);
    chk("rst_bcd",  bcd4,  16'h0000);
    chk("rst_disp", disp4, 16'hFFF0);
    chk("rst_dispn", dispn, 16'h0000);
    chk("rst_tick", tick4, 1'b0);
    rst_n = 1'b1;

    // Count up out of reset.
    cyc(4);
    chk("first_step_bcd",  bcd4,  16'h0001);
    chk("first_step_tick", tick4, 1'b1);
    cyc(36);
    chk("ten_bcd",  bcd4,  16'h0010);
    chk("ten_disp", disp4, 16'hFF10);

    // Carry chain and up wrap.
    do_ld(16'h0999);
    cyc(4);
    chk("carry_bcd", bcd4, 16'h1000);
    do_ld(16'h9999);
    cyc(4);
    chk("upwrap_bcd",  bcd4,  16'h0000);
    chk("upwrap_wrap", wrap4, 1'b1);
    cyc(1);
    chk("upwrap_pulse", wrap4, 1'b0);

    // Down wrap and borrow chain.
    up = 1'b0;
    do_ld(16'h0000);
    cyc(4);
    chk("dnwrap_bcd",  bcd4,  16'h9999);
    chk("dnwrap_wrap", wrap4, 1'b1);
    do_ld(16'h1000);
    cyc(4);
    chk("borrow_bcd",  bcd4,  16'h0999);
    chk("borrow_disp", disp4, 16'hF999);

    // Rejected load, then clr beating ld.
    do_ld(16'h12A4);
    chk("badld_bcd", bcd4, 16'h0999);
    chk("badld_err", err4, 1'b1);
    cyc(1);
    chk("badld_pulse", err4, 1'b0);
    clr = 1'b1; ld = 1'b1; ld_val = 16'h12A4;
    @(negedge clk);
    clr = 1'b0; ld = 1'b0;
    chk("clrld_bcd", bcd4, 16'h0000);
    chk("clrld_err", err4, 1'b0);

    // Enable drop holds the prescaler at 2.
    cyc(2);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(1);
    chk("resume_early", tick4, 1'b0);
    cyc(1);
    chk("resume_tick", tick4, 1'b1);
    chk("resume_bcd",  bcd4,  16'h9999);

    // clr on a step cycle suppresses the step.
    cyc(3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clrstep_tick", tick4, 1'b0);
    chk("clrstep_bcd",  bcd4,  16'h0000);

    // TICK_DIV=1 direction toggling every cycle.
    do_ld(16'h0005);
    up = 1'b1; cyc(1); chk("tog_a", bcd1, 16'h0006);
    up = 1'b0; cyc(1); chk("tog_b", bcd1, 16'h0005);
    up = 1'b1; cyc(1); chk("tog_c", bcd1, 16'h0006);

    // Asynchronous reset takes effect between clock edges.
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd4", bcd4, 16'h0000);
    chk("arst_bcd1", bcd1, 16'h0000);
    chk("arst_tick1", tick1, 1'b0);
    #1 rst_n = 1'b1;

    // Randomized traffic, checked cycle by cycle by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en  = ($urandom_range(0, 7) != 0);
      up  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 40) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) begin
        v = 16'($urandom);
      end else begin
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) v = 16'h9999;
        if ($urandom_range(0, 3) == 0) v = 16'h0000;
      end
      ld_val = v;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
